// File: rtl/dcache_mshr_q.sv
// dcache_mshr_q
//   Miss-status holding queue between the Dcache controller and the memory bus.
//   Holds up to DEPTH outstanding line requests (load misses and store
//   evictions). They are issued to memory in allocation order, completed by
//   out-of-order tagged responses and retired in allocation order.
//
// Ports
//   clock, reset            clock, synchronous active-high reset
//   i_alloc_*               up to ALLOC_PORTS allocations per cycle (all or none)
//   o_alloc_ready           at least ALLOC_PORTS entries are free
//   i_search_*              lookup ports (load forward / store coalesce)
//   o_search_*              combinational lookup results
//   o_proc2mem_*            issue of the entry at the issue pointer
//   i_mem2proc_response     nonzero: issue accepted, carries the transaction tag
//   i_mem2proc_tag/_data    completion of an in-flight load
//   o_fill_*, i_fill_ack    in-order fill handshake toward the cache
//   o_count, o_empty        occupancy
//
// Entry states
//   state        | meaning
//   S_WAITING    | allocated, not yet accepted by memory
//   S_INPROGRESS | load accepted by memory, waiting for its tag to complete
//   S_DONE       | store accepted or load data captured; ready to retire

module dcache_mshr_q #(
  parameter int DEPTH        = 8,
  parameter int ALLOC_PORTS  = 3,
  parameter int SEARCH_PORTS = 2,
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int TAG_W        = 4,
  localparam int PTR_W       = $clog2(DEPTH),
  localparam int CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [ALLOC_PORTS-1:0]           i_alloc_en,
  input  logic [ALLOC_PORTS*ADDR_W-1:0]    i_alloc_addr,
  input  logic [ALLOC_PORTS*DATA_W-1:0]    i_alloc_data,
  input  logic [ALLOC_PORTS*2-1:0]         i_alloc_cmd,
  output logic                             o_alloc_ready,
  input  logic [SEARCH_PORTS-1:0]          i_search_valid,
  input  logic [SEARCH_PORTS*ADDR_W-1:0]   i_search_addr,
  input  logic [SEARCH_PORTS-1:0]          i_search_is_store,
  input  logic [SEARCH_PORTS*DATA_W-1:0]   i_search_wr_data,
  output logic [SEARCH_PORTS-1:0]          o_search_hit,
  output logic [SEARCH_PORTS-1:0]          o_search_fwd_valid,
  output logic [SEARCH_PORTS*DATA_W-1:0]   o_search_fwd_data,
  output logic [1:0]                       o_proc2mem_command,
  output logic [ADDR_W-1:0]                o_proc2mem_addr,
  output logic [DATA_W-1:0]                o_proc2mem_data,
  input  logic [TAG_W-1:0]                 i_mem2proc_response,
  input  logic [DATA_W-1:0]                i_mem2proc_data,
  input  logic [TAG_W-1:0]                 i_mem2proc_tag,
  output logic                             o_fill_valid,
  output logic [ADDR_W-1:0]                o_fill_addr,
  output logic [DATA_W-1:0]                o_fill_data,
  output logic                             o_fill_dirty,
  input  logic                             i_fill_ack,
  output logic [CNT_W-1:0]                 o_count,
  output logic                             o_empty
);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  typedef enum logic [1:0] {
    S_WAITING    = 2'd0,
    S_INPROGRESS = 2'd1,
    S_DONE       = 2'd2
  } entry_state_e;

  logic               r_valid [DEPTH];
  logic [ADDR_W-1:0]  r_addr  [DEPTH];
  logic [DATA_W-1:0]  r_data  [DEPTH];
  logic [1:0]         r_cmd   [DEPTH];
  entry_state_e       r_state [DEPTH];
  logic [TAG_W-1:0]   r_tag   [DEPTH];
  logic               r_dirty [DEPTH];

  logic [PTR_W-1:0]   r_tail;
  logic [PTR_W-1:0]   r_issue_ptr;
  logic [PTR_W-1:0]   r_retire_ptr;
  logic [CNT_W-1:0]   r_count;

  logic [31:0]        w_need;
  logic               w_alloc_ok;
  logic [ALLOC_PORTS-1:0] w_merge;
  logic [ALLOC_PORTS-1:0] w_do_alloc;
  logic [PTR_W-1:0]   w_slot [ALLOC_PORTS];
  logic [CNT_W-1:0]   w_n_alloc;

  logic               w_completing [DEPTH];

  logic [SEARCH_PORTS-1:0] w_swr_en;
  logic [SEARCH_PORTS-1:0] w_swr_dirty;
  logic [PTR_W-1:0]   w_swr_idx [SEARCH_PORTS];

  logic               w_iss_active;
  logic               w_iss_accept;
  logic               w_ret_done;
  logic               w_ret_is_load;
  logic               w_free;

  // Occupancy
  assign o_count       = r_count;
  assign o_empty       = (r_count == '0);
  assign o_alloc_ready = (r_count <= CNT_W'(DEPTH - ALLOC_PORTS));

  // Allocation: the capacity check counts every enabled port, including loads
  // that end up merged, so acceptance never depends on the merge outcome.
  always_comb begin
    w_need = 32'(r_count);
    for (int i = 0; i < ALLOC_PORTS; i++) begin
      if (i_alloc_en[i]) w_need = w_need + 32'd1;
    end
    w_alloc_ok = (w_need <= 32'(DEPTH));
    w_n_alloc  = '0;
    w_merge    = '0;
    w_do_alloc = '0;
    for (int i = 0; i < ALLOC_PORTS; i++) begin
      w_slot[i] = r_tail + PTR_W'(w_n_alloc);
      // Merge only against entries already held; same-cycle duplicates allocate.
      for (int e = 0; e < DEPTH; e++) begin
        if (i_alloc_en[i] && i_alloc_cmd[i*2 +: 2] == BUS_LOAD &&
            r_valid[e] && r_cmd[e] == BUS_LOAD &&
            r_addr[e] == i_alloc_addr[i*ADDR_W +: ADDR_W]) begin
          w_merge[i] = 1'b1;
        end
      end
      w_do_alloc[i] = w_alloc_ok && i_alloc_en[i] && !w_merge[i];
      if (w_do_alloc[i]) w_n_alloc = w_n_alloc + CNT_W'(1);
    end
  end

  // Completion: an in-flight load whose tag is returned this cycle.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      w_completing[e] = r_valid[e] && (r_state[e] == S_INPROGRESS) &&
                        (i_mem2proc_tag != '0) && (r_tag[e] == i_mem2proc_tag);
    end
  end

  // Search: youngest match is the one furthest from the retire pointer.
  // A load completing this cycle counts as filled for store coalescing, so a
  // store landing on the fill cycle is not lost.
  always_comb begin
    logic             v_found;
    logic [PTR_W-1:0] v_idx;
    logic [PTR_W-1:0] v_age;
    logic [PTR_W-1:0] v_e_age;
    o_search_hit       = '0;
    o_search_fwd_valid = '0;
    o_search_fwd_data  = '0;
    w_swr_en           = '0;
    w_swr_dirty        = '0;
    v_found            = 1'b0;
    v_idx              = '0;
    v_age              = '0;
    v_e_age            = '0;
    for (int p = 0; p < SEARCH_PORTS; p++) begin
      w_swr_idx[p] = '0;
      v_found      = 1'b0;
      v_idx        = '0;
      v_age        = '0;
      for (int e = 0; e < DEPTH; e++) begin
        v_e_age = PTR_W'(e) - r_retire_ptr;
        if (r_valid[e] && r_addr[e] == i_search_addr[p*ADDR_W +: ADDR_W]) begin
          if (!v_found || v_e_age > v_age) begin
            v_found = 1'b1;
            v_idx   = PTR_W'(e);
            v_age   = v_e_age;
          end
        end
      end
      if (i_search_valid[p] && v_found) begin
        if (!i_search_is_store[p]) begin
          o_search_hit[p] = 1'b1;
          if (r_cmd[v_idx] == BUS_STORE) begin
            o_search_fwd_valid[p]                   = 1'b1;
            o_search_fwd_data[p*DATA_W +: DATA_W]   = r_data[v_idx];
          end
        end else if (r_cmd[v_idx] == BUS_STORE && r_state[v_idx] == S_WAITING) begin
          o_search_hit[p] = 1'b1;
          w_swr_en[p]     = 1'b1;
          w_swr_idx[p]    = v_idx;
        end else if (r_cmd[v_idx] == BUS_LOAD &&
                     (r_state[v_idx] == S_DONE || w_completing[v_idx])) begin
          o_search_hit[p] = 1'b1;
          w_swr_en[p]     = 1'b1;
          w_swr_dirty[p]  = 1'b1;
          w_swr_idx[p]    = v_idx;
        end
      end
    end
  end

  // Issue
  assign w_iss_active       = r_valid[r_issue_ptr] && (r_state[r_issue_ptr] == S_WAITING);
  assign w_iss_accept       = w_iss_active && (i_mem2proc_response != '0);
  assign o_proc2mem_command = w_iss_active ? r_cmd[r_issue_ptr]  : BUS_NONE;
  assign o_proc2mem_addr    = w_iss_active ? r_addr[r_issue_ptr] : '0;
  assign o_proc2mem_data    = w_iss_active ? r_data[r_issue_ptr] : '0;

  // Retire
  assign w_ret_done    = r_valid[r_retire_ptr] && (r_state[r_retire_ptr] == S_DONE);
  assign w_ret_is_load = (r_cmd[r_retire_ptr] == BUS_LOAD);
  assign w_free        = w_ret_done && (!w_ret_is_load || i_fill_ack);
  assign o_fill_valid  = w_ret_done && w_ret_is_load;
  assign o_fill_addr   = o_fill_valid ? r_addr[r_retire_ptr]  : '0;
  assign o_fill_data   = o_fill_valid ? r_data[r_retire_ptr]  : '0;
  assign o_fill_dirty  = o_fill_valid && r_dirty[r_retire_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int e = 0; e < DEPTH; e++) begin
        r_valid[e] <= 1'b0;
        r_addr[e]  <= '0;
        r_data[e]  <= '0;
        r_cmd[e]   <= BUS_NONE;
        r_state[e] <= S_WAITING;
        r_tag[e]   <= '0;
        r_dirty[e] <= 1'b0;
      end
      r_tail       <= '0;
      r_issue_ptr  <= '0;
      r_retire_ptr <= '0;
      r_count      <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (w_completing[e]) begin
          r_state[e] <= S_DONE;
          r_data[e]  <= i_mem2proc_data;
        end
      end

      if (w_iss_accept) begin
        if (r_cmd[r_issue_ptr] == BUS_LOAD) begin
          r_state[r_issue_ptr] <= S_INPROGRESS;
          r_tag[r_issue_ptr]   <= i_mem2proc_response;
        end else begin
          r_state[r_issue_ptr] <= S_DONE;
        end
        r_issue_ptr <= r_issue_ptr + PTR_W'(1);
      end

      // Placed after the fill capture so coalesced store data wins.
      for (int p = 0; p < SEARCH_PORTS; p++) begin
        if (w_swr_en[p]) begin
          r_data[w_swr_idx[p]] <= i_search_wr_data[p*DATA_W +: DATA_W];
          if (w_swr_dirty[p]) r_dirty[w_swr_idx[p]] <= 1'b1;
        end
      end

      if (w_free) begin
        r_valid[r_retire_ptr] <= 1'b0;
        r_retire_ptr          <= r_retire_ptr + PTR_W'(1);
      end

      for (int i = 0; i < ALLOC_PORTS; i++) begin
        if (w_do_alloc[i]) begin
          r_valid[w_slot[i]] <= 1'b1;
          r_addr[w_slot[i]]  <= i_alloc_addr[i*ADDR_W +: ADDR_W];
          r_data[w_slot[i]]  <= i_alloc_data[i*DATA_W +: DATA_W];
          r_cmd[w_slot[i]]   <= i_alloc_cmd[i*2 +: 2];
          r_state[w_slot[i]] <= S_WAITING;
          r_tag[w_slot[i]]   <= '0;
          r_dirty[w_slot[i]] <= 1'b0;
        end
      end

      r_tail  <= r_tail + PTR_W'(w_n_alloc);
      r_count <= r_count + w_n_alloc - CNT_W'(w_free);
    end
  end

endmodule

// File: tb/tb_dcache_mshr_q.sv
module tb_dcache_mshr_q;
  localparam int DEPTH = 8, AP = 3, SP = 2, AW = 64, DW = 64, TW = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [AP-1:0]    alloc_en;
  logic [AP*AW-1:0] alloc_addr;
  logic [AP*DW-1:0] alloc_data;
  logic [AP*2-1:0]  alloc_cmd;
  logic             alloc_ready;
  logic [SP-1:0]    search_valid, search_is_store, search_hit, search_fwd_valid;
  logic [SP*AW-1:0] search_addr;
  logic [SP*DW-1:0] search_wr_data, search_fwd_data;
  logic [1:0]       cmd;
  logic [AW-1:0]    p2m_addr, fill_addr;
  logic [DW-1:0]    p2m_data, mem_data, fill_data;
  logic [TW-1:0]    mem_resp, mem_tag;
  logic             fill_valid, fill_dirty, fill_ack, empty;
  logic [3:0]       count;

  always #5 clock = ~clock;

  dcache_mshr_q #(.DEPTH(DEPTH), .ALLOC_PORTS(AP), .SEARCH_PORTS(SP),
                  .ADDR_W(AW), .DATA_W(DW), .TAG_W(TW)) dut (
    .clock(clock), .reset(reset),
    .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr), .i_alloc_data(alloc_data),
    .i_alloc_cmd(alloc_cmd), .o_alloc_ready(alloc_ready),
    .i_search_valid(search_valid), .i_search_addr(search_addr),
    .i_search_is_store(search_is_store), .i_search_wr_data(search_wr_data),
    .o_search_hit(search_hit), .o_search_fwd_valid(search_fwd_valid),
    .o_search_fwd_data(search_fwd_data),
    .o_proc2mem_command(cmd), .o_proc2mem_addr(p2m_addr), .o_proc2mem_data(p2m_data),
    .i_mem2proc_response(mem_resp), .i_mem2proc_data(mem_data), .i_mem2proc_tag(mem_tag),
    .o_fill_valid(fill_valid), .o_fill_addr(fill_addr), .o_fill_data(fill_data),
    .o_fill_dirty(fill_dirty), .i_fill_ack(fill_ack),
    .o_count(count), .o_empty(empty));

  // Reference model: an ordered list of outstanding requests, oldest first,
  // plus how many of them memory has already accepted.
  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    bit          is_store;
    int          st;       // 0 waiting, 1 in flight, 2 done
    logic [3:0]  tag;
    bit          dirty;
  } ent_t;

  ent_t q[$];
  int   m_iss = 0;
  int   n_vec = 0, n_mis = 0;
  bit   chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void m_search(input int p, output bit hit, output bit fv,
                                   output logic [63:0] fd, output bit wr,
                                   output int idx, output bit dty);
    bit found;
    found = 0; hit = 0; fv = 0; fd = '0; wr = 0; idx = 0; dty = 0;
    if (search_valid[p]) begin
      for (int k = q.size() - 1; k >= 0; k--) begin
        if (!found && q[k].addr == search_addr[p*AW +: AW]) begin
          found = 1;
          if (!search_is_store[p]) begin
            hit = 1;
            if (q[k].is_store) begin fv = 1; fd = q[k].data; end
          end else if (q[k].is_store && q[k].st == 0) begin
            hit = 1; wr = 1; idx = k;
          end else if (!q[k].is_store &&
                       (q[k].st == 2 || (q[k].st == 1 && mem_tag != 0 && q[k].tag == mem_tag))) begin
            hit = 1; wr = 1; idx = k; dty = 1;
          end
        end
      end
    end
  endfunction

  function automatic void model_step();
    bit h[SP], f[SP], w[SP], d[SP];
    int ix[SP];
    logic [63:0] fd[SP];
    bit iss, ret, ok, merge;
    ent_t nw[$];
    ent_t e;
    logic [63:0] a;
    logic [1:0] c;
    if (reset) begin
      q.delete();
      m_iss = 0;
      return;
    end
    for (int p = 0; p < SP; p++) m_search(p, h[p], f[p], fd[p], w[p], ix[p], d[p]);
    iss = (m_iss < q.size()) && (mem_resp != 0);
    ret = (q.size() > 0) && (q[0].st == 2) && (q[0].is_store || fill_ack);
    ok  = (q.size() + $countones(alloc_en)) <= DEPTH;
    if (ok) begin
      for (int i = 0; i < AP; i++) begin
        if (alloc_en[i]) begin
          a = alloc_addr[i*AW +: AW];
          c = alloc_cmd[i*2 +: 2];
          merge = 0;
          if (c == 2'd1)
            for (int k = 0; k < q.size(); k++)
              if (!q[k].is_store && q[k].addr == a) merge = 1;
          if (!merge) begin
            e.addr = a; e.data = alloc_data[i*DW +: DW]; e.is_store = (c == 2'd2);
            e.st = 0; e.tag = 0; e.dirty = 0;
            nw.push_back(e);
          end
        end
      end
    end
    for (int k = 0; k < q.size(); k++)
      if (q[k].st == 1 && mem_tag != 0 && q[k].tag == mem_tag) begin
        q[k].st = 2; q[k].data = mem_data;
      end
    if (iss) begin
      if (q[m_iss].is_store) q[m_iss].st = 2;
      else begin q[m_iss].st = 1; q[m_iss].tag = mem_resp; end
      m_iss++;
    end
    for (int p = 0; p < SP; p++)
      if (w[p]) begin
        q[ix[p]].data = search_wr_data[p*DW +: DW];
        if (d[p]) q[ix[p]].dirty = 1;
      end
    if (ret) begin
      void'(q.pop_front());
      m_iss--;
    end
    foreach (nw[i]) q.push_back(nw[i]);
  endfunction

  always @(posedge clock) model_step();

  // Compare DUT outputs against the model every cycle, away from the edge.
  always @(negedge clock) begin
    int n;
    logic [1:0] ec;
    bit fv, h, f, w, d;
    int ix;
    logic [63:0] fd;
    if (chk_en) begin
      n = q.size();
      chk("count", 64'(count), 64'(n));
      chk("empty", 64'(empty), 64'(n == 0));
      chk("alloc_ready", 64'(alloc_ready), 64'((DEPTH - n) >= AP));
      ec = (m_iss < n) ? (q[m_iss].is_store ? 2'd2 : 2'd1) : 2'd0;
      chk("command", 64'(cmd), 64'(ec));
      if (ec != 0) begin
        chk("issue_addr", p2m_addr, q[m_iss].addr);
        chk("issue_data", p2m_data, q[m_iss].data);
      end
      fv = (n > 0) && q[0].st == 2 && !q[0].is_store;
      chk("fill_valid", 64'(fill_valid), 64'(fv));
      if (fv) begin
        chk("fill_addr", fill_addr, q[0].addr);
        chk("fill_data", fill_data, q[0].data);
        chk("fill_dirty", 64'(fill_dirty), 64'(q[0].dirty));
      end
      for (int p = 0; p < SP; p++) begin
        m_search(p, h, f, fd, w, ix, d);
        chk($sformatf("search_hit%0d", p), 64'(search_hit[p]), 64'(h));
        chk($sformatf("fwd_valid%0d", p), 64'(search_fwd_valid[p]), 64'(f));
        if (f) chk($sformatf("fwd_data%0d", p), search_fwd_data[p*DW +: DW], fd);
      end
    end
  end

  task automatic idle();
    alloc_en = '0; alloc_addr = '0; alloc_data = '0; alloc_cmd = '0;
    search_valid = '0; search_addr = '0; search_is_store = '0; search_wr_data = '0;
    mem_resp = '0; mem_data = '0; mem_tag = '0; fill_ack = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_alloc(input int p, input logic [63:0] a, input logic [63:0] dd,
                           input logic [1:0] c);
    alloc_en[p] = 1'b1;
    alloc_addr[p*AW +: AW] = a;
    alloc_data[p*DW +: DW] = dd;
    alloc_cmd[p*2 +: 2] = c;
  endtask

  task automatic set_search(input int p, input bit st, input logic [63:0] a,
                            input logic [63:0] dd);
    search_valid[p] = 1'b1;
    search_is_store[p] = st;
    search_addr[p*AW +: AW] = a;
    search_wr_data[p*DW +: DW] = dd;
  endtask

  // Serve memory until the queue empties: accept every issue, complete each
  // load one cycle after acceptance, acknowledge every fill.
  task automatic drain(input string nm);
    logic [3:0] pend[$];
    logic [3:0] nt;
    int c;
    nt = 4'd1;
    c = 0;
    while (c < 200 && !(empty && pend.size() == 0)) begin
      idle();
      if (pend.size() > 0) begin
        mem_tag = pend.pop_front();
        mem_data = 64'hF000 | 64'(mem_tag);
      end
      if (cmd == 2'd1) begin
        mem_resp = nt;
        pend.push_back(nt);
        nt = (nt == 4'd15) ? 4'd1 : nt + 4'd1;
      end else if (cmd == 2'd2) begin
        mem_resp = 4'd1;
      end
      fill_ack = fill_valid;
      cyc();
      c++;
    end
    idle();
    #1;
    chk(nm, 64'(empty), 64'd1);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_ready", 64'(alloc_ready), 64'd1);
    chk("rst_cmd", 64'(cmd), 64'd0);
    chk("rst_fill", 64'(fill_valid), 64'd0);

    // Single load, tag 3, fill 0xDEAD
    set_alloc(0, 64'h100, 64'h0, 2'd1); cyc(); idle(); #1;
    chk("t1_cmd", 64'(cmd), 64'd1);
    chk("t1_addr", p2m_addr, 64'h100);
    mem_resp = 4'd3; cyc(); idle(); cyc();
    mem_tag = 4'd3; mem_data = 64'hDEAD; cyc(); idle(); #1;
    chk("t1_fill_valid", 64'(fill_valid), 64'd1);
    chk("t1_fill_data", fill_data, 64'hDEAD);
    fill_ack = 1'b1; cyc(); idle(); #1;
    chk("t1_empty", 64'(empty), 64'd1);

    // All-or-nothing allocation at the capacity boundary
    set_alloc(0, 64'h1000, 64'd1, 2'd2); set_alloc(1, 64'h1040, 64'd2, 2'd2);
    set_alloc(2, 64'h1080, 64'd3, 2'd2); cyc(); idle();
    set_alloc(0, 64'h10C0, 64'd4, 2'd2); set_alloc(1, 64'h1100, 64'd5, 2'd2);
    set_alloc(2, 64'h1140, 64'd6, 2'd2); cyc(); idle(); #1;
    chk("t2_count6", 64'(count), 64'd6);
    chk("t2_not_ready", 64'(alloc_ready), 64'd0);
    set_alloc(0, 64'h2000, 64'd0, 2'd1); set_alloc(1, 64'h2040, 64'd0, 2'd1);
    set_alloc(2, 64'h2080, 64'd0, 2'd1); cyc(); idle(); #1;
    chk("t2_rejected", 64'(count), 64'd6);
    mem_resp = 4'd1; cyc(); idle(); cyc(); #1;
    chk("t2_count5", 64'(count), 64'd5);
    set_alloc(0, 64'h2000, 64'd0, 2'd1); set_alloc(1, 64'h2040, 64'd0, 2'd1);
    set_alloc(2, 64'h2080, 64'd0, 2'd1); cyc(); idle(); #1;
    chk("t2_count8", 64'(count), 64'd8);
    drain("t2_drain");

    // Merge of a duplicate load; store lookup on a waiting load misses
    set_alloc(0, 64'h200, 64'd0, 2'd1); cyc(); idle();
    set_alloc(1, 64'h200, 64'd0, 2'd1);
    set_search(0, 1'b0, 64'h200, 64'd0);
    set_search(1, 1'b1, 64'h200, 64'h99); #1;
    chk("t3_load_hit", 64'(search_hit[0]), 64'd1);
    chk("t3_store_miss", 64'(search_hit[1]), 64'd0);
    cyc(); idle(); #1;
    chk("t3_merged", 64'(count), 64'd1);
    drain("t3_drain");

    // Store coalescing into a waiting eviction
    set_alloc(2, 64'h300, 64'h11, 2'd2); cyc(); idle();
    set_search(0, 1'b1, 64'h300, 64'h55);
    set_search(1, 1'b0, 64'h300, 64'h0); #1;
    chk("t4_store_hit", 64'(search_hit[0]), 64'd1);
    chk("t4_fwd_valid", 64'(search_fwd_valid[1]), 64'd1);
    chk("t4_fwd_old", search_fwd_data[DW +: DW], 64'h11);
    cyc(); idle(); #1;
    chk("t4_issue_data", p2m_data, 64'h55);
    drain("t4_drain");

    // Out-of-order completion, in-order fills
    set_alloc(0, 64'h400, 64'd0, 2'd1); set_alloc(1, 64'h500, 64'd0, 2'd1); cyc(); idle();
    mem_resp = 4'd1; cyc(); idle();
    mem_resp = 4'd2; cyc(); idle();
    mem_tag = 4'd2; mem_data = 64'hB2; cyc(); idle(); #1;
    chk("t5_no_fill", 64'(fill_valid), 64'd0);
    mem_tag = 4'd1; mem_data = 64'hB1; cyc(); idle(); #1;
    chk("t5_fill1_addr", fill_addr, 64'h400);
    chk("t5_fill1_data", fill_data, 64'hB1);
    fill_ack = 1'b1; cyc(); idle(); #1;
    chk("t5_fill2_addr", fill_addr, 64'h500);
    chk("t5_fill2_data", fill_data, 64'hB2);
    fill_ack = 1'b1; cyc(); idle(); #1;
    chk("t5_empty", 64'(empty), 64'd1);

    // Store lookup on the fill cycle wins over fill data
    set_alloc(0, 64'h600, 64'd0, 2'd1); cyc(); idle();
    mem_resp = 4'd4; cyc(); idle(); cyc();
    mem_tag = 4'd4; mem_data = 64'hAAAA;
    set_search(0, 1'b1, 64'h600, 64'h77); #1;
    chk("t6_hit", 64'(search_hit[0]), 64'd1);
    cyc(); idle(); #1;
    chk("t6_fill_valid", 64'(fill_valid), 64'd1);
    chk("t6_fill_data", fill_data, 64'h77);
    chk("t6_fill_dirty", 64'(fill_dirty), 64'd1);
    fill_ack = 1'b1; cyc(); idle();

    // Reset mid-flight; the stale tag must be ignored
    set_alloc(0, 64'h700, 64'd0, 2'd1); cyc(); idle();
    mem_resp = 4'd5; cyc(); idle();
    reset = 1'b1; cyc();
    reset = 1'b0; mem_tag = 4'd5; mem_data = 64'h1; cyc(); idle(); #1;
    chk("t7_empty", 64'(empty), 64'd1);
    chk("t7_no_fill", 64'(fill_valid), 64'd0);
    cyc(); #1;
    chk("t7_still_empty", 64'(count), 64'd0);

    @(negedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not reach the end, got timeout expected finish");
    $fatal(1);
  end

endmodule
